mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: P_STREAK, default 4, max consecutive data-port grants while an instruction request waits (1..15).
REQ-002 Widths: address `HBIT_ADDR+1 bits, data `HBIT_DATA+1 bits (24), macros from src2/sizes.vh.
REQ-003 iw_clk  in  1  sole clock; all state updates on posedge.
REQ-004 iw_rst  in  1  reset, synchronous, active-high.
REQ-005 iw_i_req  in  1  instruction-port read request.
REQ-006 iw_i_addr  in  ADDR  instruction read address.
REQ-007 ow_i_ack  out  1  instruction request accepted this cycle (combinational).
REQ-008 or_i_rvalid  out  1  instruction read data valid.
REQ-009 ow_i_rdata  out  DATA  instruction read data.
REQ-010 iw_d_req  in  1  data-port request.
REQ-011 iw_d_we  in  1  data-port write enable (1 = write, 0 = read).
REQ-012 iw_d_addr  in  ADDR  data address.
REQ-013 iw_d_wdata  in  DATA  data write value.
REQ-014 ow_d_ack  out  1  data request accepted this cycle (combinational).
REQ-015 or_d_rvalid  out  1  data read data valid.
REQ-016 ow_d_rdata  out  DATA  data read data.
REQ-017 ow_m_we / ow_m_addr / ow_m_wdata  out  1/ADDR/DATA  to the mem block's iw_we/iw_addr/iw_wdata.
REQ-018 iw_m_rdata  in  DATA  from the mem block's or_rdata (registered, 1-cycle read latency).

Function
REQ-019 Grant per cycle at most one port; ow_i_ack and ow_d_ack never both 1.
REQ-020 Only d_req -> data granted; only i_req -> instruction granted; neither -> idle.
REQ-021 Both requesting -> data granted unless streak counter == P_STREAK, then instruction granted.
REQ-022 Streak counter (4-bit): +1 when data granted while i_req high; cleared when instruction granted or i_req low; saturates at P_STREAK.
REQ-023 Granted cycle N: ow_m_addr = granted address; ow_m_we = iw_d_we if data granted, else 0; ow_m_wdata = iw_d_wdata.
REQ-024 Idle cycle: ow_m_we = 0; ow_m_addr holds last granted address (registered copy); ow_m_wdata = 0.
REQ-025 Read granted in cycle N -> matching rvalid = 1 in cycle N+1 only, rdata = iw_m_rdata in that cycle.
REQ-026 Data write grants produce no rvalid.
REQ-027 Per port, rdata holds last returned value when rvalid = 0 (hold register loaded when rvalid = 1).
REQ-028 Back-to-back grants every cycle supported; throughput 1 access/cycle, responses in grant order.
REQ-029 Requester keeps req/addr/we/wdata stable until ack; arbiter holds no request queue.
REQ-030 Same-address write then read (consecutive cycles) -> read returns the new value.

Reset
REQ-031 While iw_rst = 1: both acks 0, ow_m_we = 0, no memory access.
REQ-032 At posedge with iw_rst = 1: rvalids 0, hold registers 0, streak 0, address register 0.
REQ-033 Read granted in cycle N with iw_rst = 1 at the N->N+1 edge -> response dropped, rvalid stays 0.
REQ-034 First grant possible in the first cycle iw_rst = 0.

Verification
REQ-035 mem preloaded addr 0x010 = 0x123456; i_req addr 0x010 alone -> i_ack cycle N, i_rvalid = 1 cycle N+1, i_rdata = 0x123456, held afterwards.
REQ-036 d write addr 0x020 data 0xABCDEF, next cycle d read 0x020 -> d_rvalid one cycle later with 0xABCDEF; no rvalid for the write.
REQ-037 i_req and d_req high continuously, P_STREAK = 4 -> grant pattern D,D,D,D,I repeating; never both acks.
REQ-038 d_req and i_req alternate single-cycle -> every request acked the cycle it is raised; rvalids on correct ports in order.
REQ-039 iw_rst raised the cycle after a read grant -> no rvalid, all outputs 0; after release a read at 0x010 returns 0x123456 with latency 1.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port memory arbiter: an instruction read port and a data read/write port
// share one single-ported memory with 1-cycle registered read latency.
module mem_arb #(
  parameter int unsigned P_STREAK = 4,
  parameter int unsigned P_ADDR_W = 12,
  parameter int unsigned P_DATA_W = 24
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_i_req,
  input  logic [P_ADDR_W-1:0] iw_i_addr,
  output logic                ow_i_ack,
  output logic                or_i_rvalid,
  output logic [P_DATA_W-1:0] ow_i_rdata,
  input  logic                iw_d_req,
  input  logic                iw_d_we,
  input  logic [P_ADDR_W-1:0] iw_d_addr,
  input  logic [P_DATA_W-1:0] iw_d_wdata,
  output logic                ow_d_ack,
  output logic                or_d_rvalid,
  output logic [P_DATA_W-1:0] ow_d_rdata,
  output logic                ow_m_we,
  output logic [P_ADDR_W-1:0] ow_m_addr,
  output logic [P_DATA_W-1:0] ow_m_wdata,
  input  logic [P_DATA_W-1:0] iw_m_rdata
);

  // Handshake: a request is presented by holding req (and its address/data)
  // stable; ack is high in the cycle the request is taken, and for reads the
  // matching rvalid follows exactly one cycle later.

  localparam logic [3:0] STREAK_MAX = 4'(P_STREAK);

  logic                gnt_i;
  logic                gnt_d;
  logic                streak_full;
  logic [3:0]          streak_q, streak_d;
  logic [P_ADDR_W-1:0] addr_q, addr_d;
  logic                i_pend_q, i_pend_d;
  logic                d_pend_q, d_pend_d;
  logic [P_DATA_W-1:0] i_hold_q, i_hold_d;
  logic [P_DATA_W-1:0] d_hold_q, d_hold_d;

  // Data port wins by default; the instruction port gets a guaranteed slot
  // once the data port has taken P_STREAK grants in a row while it waited.
  always_comb begin
    streak_full = (streak_q == STREAK_MAX);
    gnt_d       = !iw_rst && iw_d_req && !(iw_i_req && streak_full);
    gnt_i       = !iw_rst && iw_i_req && !gnt_d;
  end

  always_comb begin
    addr_d = addr_q;
    if (gnt_d) begin
      addr_d = iw_d_addr;
    end else if (gnt_i) begin
      addr_d = iw_i_addr;
    end

    streak_d = '0;
    if (iw_i_req && gnt_d) begin
      streak_d = streak_full ? streak_q : streak_q + 4'd1;
    end

    i_pend_d = gnt_i;
    d_pend_d = gnt_d && !iw_d_we;

    i_hold_d = i_pend_q ? iw_m_rdata : i_hold_q;
    d_hold_d = d_pend_q ? iw_m_rdata : d_hold_q;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      streak_q <= '0;
      addr_q   <= '0;
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      streak_q <= streak_d;
      addr_q   <= addr_d;
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

  // Reset forces every output quiet, including a response already in flight.
  always_comb begin
    ow_i_ack    = gnt_i;
    ow_d_ack    = gnt_d;
    ow_m_we     = gnt_d && iw_d_we;
    ow_m_addr   = iw_rst ? '0 : addr_d;
    ow_m_wdata  = (gnt_i || gnt_d) ? iw_d_wdata : '0;
    or_i_rvalid = i_pend_q && !iw_rst;
    or_d_rvalid = d_pend_q && !iw_rst;
    ow_i_rdata  = iw_rst ? '0 : (i_pend_q ? iw_m_rdata : i_hold_q);
    ow_d_rdata  = iw_rst ? '0 : (d_pend_q ? iw_m_rdata : d_hold_q);
  end

  a_one_grant : assert property (@(posedge iw_clk) !(ow_i_ack && ow_d_ack));
  a_rst_quiet : assert property (@(posedge iw_clk) iw_rst |-> !ow_i_ack && !ow_d_ack && !ow_m_we);

endmodule
